// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave receive path: the default byte and
// frame geometry, the derived frame word width and the receive FSM states.
// No ports; imported by spi_sync_edge and spi_slave_frame_rx.
// ---------------------------------------------------------------------------
package spi_pkg;

    // Default geometry: two 8-bit bytes form one 16-bit frame word.
    localparam int SPI_DATA_W      = 8;
    localparam int SPI_FRAME_BYTES = 2;
    localparam int FRAME_W         = SPI_DATA_W * SPI_FRAME_BYTES;

    // Receive FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flops and detects its rising and falling edges.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-low reset
//   din    in   asynchronous pin
//   level  out  synchronized level, delayed so it lines up with rise/fall
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
//
// All three outputs are registered and share the same delay from the pin,
// so a data pin's level can be sampled in the cycle its clock pin's rise
// output is high. SYNC_STAGES must be 2 or 3.
// ---------------------------------------------------------------------------
module spi_sync_edge import spi_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q,  prev_d;
    logic                   level_q, level_d;
    logic                   rise_q,  rise_d;
    logic                   fall_q,  fall_d;
    logic                   sync_lvl;

    assign sync_lvl = chain_q[SYNC_STAGES-1];

    // Shift the pin into the synchronizer; prev_q holds the previous
    // synchronized level so edges are a simple compare against it.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], din};
        prev_d  = sync_lvl;
        level_d = sync_lvl;
        rise_d  = sync_lvl & ~prev_q;
        fall_d  = ~sync_lvl & prev_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_frame_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_frame_rx
// SPI mode-0 slave receiver. Oversamples sclk/mosi/start in the clk domain,
// shifts in MSB-first bytes and assembles FRAME_BYTES of them into one word.
//
// Ports:
//   clk            in   system clock (only clock)
//   reset          in   synchronous active-low reset
//   sclk           in   SPI clock, asynchronous, idle low
//   mosi           in   SPI data, asynchronous
//   start          in   frame select, high for the whole frame
//   rx_byte        out  last completed byte
//   rx_byte_valid  out  one-cycle strobe, rx_byte updated
//   frame_data     out  last good frame, first byte in the MSBs
//   frame_valid    out  one-cycle strobe, frame_data updated
//   frame_err      out  one-cycle strobe, aborted or overlong frame
//   busy           out  high while the FSM is not IDLE
//
// Requires DATA_W >= 2 and FRAME_BYTES >= 2.
// ---------------------------------------------------------------------------
module spi_slave_frame_rx import spi_pkg::*; #(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int FRAME_BYTES = SPI_FRAME_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          start,
    output logic [DATA_W-1:0]             rx_byte,
    output logic                          rx_byte_valid,
    output logic [DATA_W*FRAME_BYTES-1:0] frame_data,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int FW   = DATA_W * FRAME_BYTES;
    localparam int BCW  = $clog2(DATA_W);
    localparam int YCW  = $clog2(FRAME_BYTES);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);
    localparam logic [YCW-1:0] BYTE_LAST = YCW'(FRAME_BYTES - 1);

    // Conditioned pin events
    logic sclk_rise, start_rise, start_fall, mosi_s;
    logic sclk_level_unused, sclk_fall_unused;
    logic start_level_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .din   (mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .clk   (clk),
        .reset (reset),
        .din   (start),
        .level (start_level_unused),
        .rise  (start_rise),
        .fall  (start_fall)
    );

    // FSM, shift and assembly state
    rx_state_e         state_q,     state_d;
    logic [BCW-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [YCW-1:0]    byte_cnt_q,  byte_cnt_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic [FW-1:0]     word_q,      word_d;
    logic              ovf_q,       ovf_d;

    // Completed-byte/frame hand-off into the output registers
    logic              byte_pend_q,  byte_pend_d;
    logic [DATA_W-1:0] byte_hold_q,  byte_hold_d;
    logic              frame_pend_q, frame_pend_d;

    // Output registers
    logic [DATA_W-1:0] rx_byte_q,       rx_byte_d;
    logic              rx_byte_valid_q, rx_byte_valid_d;
    logic [FW-1:0]     frame_data_q,    frame_data_d;
    logic              frame_valid_q,   frame_valid_d;
    logic              frame_err_q,     frame_err_d;

    logic [DATA_W-1:0] new_byte;
    logic              frame_done;

    assign new_byte = {shreg_q[DATA_W-2:0], mosi_s};

    // Receive FSM. In SHIFT the sclk edge is handled before start_fall, so a
    // frame whose last bit and start drop arrive together still completes.
    // Completed bytes and frames are staged in *_pend and published to the
    // outputs one cycle later, which keeps rx_byte_valid and frame_valid
    // aligned with each other.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        ovf_d        = ovf_q;
        byte_pend_d  = 1'b0;
        byte_hold_d  = byte_hold_q;
        frame_pend_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_done   = 1'b0;

        rx_byte_valid_d = byte_pend_q;
        rx_byte_d       = byte_pend_q ? byte_hold_q : rx_byte_q;
        frame_valid_d   = frame_pend_q;
        frame_data_d    = frame_pend_q ? word_q : frame_data_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                ovf_d      = 1'b0;
                if (start_rise) begin
                    state_d = SHIFT;
                    shreg_d = '0;
                    word_d  = '0;
                end
            end

            SHIFT: begin
                if (sclk_rise) begin
                    shreg_d = new_byte;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d   = '0;
                        byte_pend_d = 1'b1;
                        byte_hold_d = new_byte;
                        word_d      = {word_q[FW-DATA_W-1:0], new_byte};
                        if (byte_cnt_q == BYTE_LAST) begin
                            byte_cnt_d   = '0;
                            frame_pend_d = 1'b1;
                            frame_done   = 1'b1;
                            state_d      = DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                if (start_fall && !frame_done) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                end
            end

            DONE: begin
                // Extra sclk edges after a full frame mark it overlong; the
                // error is reported once start drops.
                if (sclk_rise) begin
                    ovf_d = 1'b1;
                end
                if (start_fall) begin
                    frame_err_d = ovf_q | sclk_rise;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            byte_cnt_q      <= '0;
            shreg_q         <= '0;
            word_q          <= '0;
            ovf_q           <= 1'b0;
            byte_pend_q     <= 1'b0;
            byte_hold_q     <= '0;
            frame_pend_q    <= 1'b0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            frame_data_q    <= '0;
            frame_valid_q   <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            shreg_q         <= shreg_d;
            word_q          <= word_d;
            ovf_q           <= ovf_d;
            byte_pend_q     <= byte_pend_d;
            byte_hold_q     <= byte_hold_d;
            frame_pend_q    <= frame_pend_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            frame_data_q    <= frame_data_d;
            frame_valid_q   <= frame_valid_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign frame_data    = frame_data_q;
    assign frame_valid   = frame_valid_q;
    assign frame_err     = frame_err_q;
    assign busy          = (state_q != IDLE);

endmodule
